// File: rtl/alu_issue_stage_if.sv
// ID/EX issue-stage bus: upstream instruction/operand handshake, writeback
// forwarding sources, downstream control and the registered ID/EX outputs.
//   master : drives instruction, forwarding, ex_stall/flush; observes outputs
//   slave  : the issue stage itself
interface alu_issue_stage_if;
   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;
   localparam int unsigned CW = 3;

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] instr;
   logic [DW-1:0] pc;
   logic [DW-1:0] rs_data;
   logic [DW-1:0] rt_data;
   logic          exm_wr_en;
   logic [RW-1:0] exm_wr_addr;
   logic [DW-1:0] exm_wr_data;
   logic          mwb_wr_en;
   logic [RW-1:0] mwb_wr_addr;
   logic [DW-1:0] mwb_wr_data;
   logic          ex_stall;
   logic          flush;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [CW-1:0] alu_ctrl;
   logic          ex_valid;
   logic [RW-1:0] ex_rd;
   logic          ex_reg_wr;
   logic          ex_mem_rd;
   logic          ex_mem_wr;
   logic [DW-1:0] ex_store_data;
   logic [DW-1:0] ex_pc;
   logic          ex_illegal;

   modport master (
      output in_valid, instr, pc, rs_data, rt_data,
      output exm_wr_en, exm_wr_addr, exm_wr_data,
      output mwb_wr_en, mwb_wr_addr, mwb_wr_data,
      output ex_stall, flush,
      input  in_ready, alu_a, alu_b, alu_ctrl, ex_valid, ex_rd,
      input  ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_store_data, ex_pc, ex_illegal
   );

   modport slave (
      input  in_valid, instr, pc, rs_data, rt_data,
      input  exm_wr_en, exm_wr_addr, exm_wr_data,
      input  mwb_wr_en, mwb_wr_addr, mwb_wr_data,
      input  ex_stall, flush,
      output in_ready, alu_a, alu_b, alu_ctrl, ex_valid, ex_rd,
      output ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_store_data, ex_pc, ex_illegal
   );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes one instruction per cycle into ALU control,
// resolves rs/rt through EX/MEM and MEM/WB forwarding, inserts a bubble on
// load-use hazards and registers the result into the ID/EX register.
// Ports: clk, reset (synchronous, active-high), bus (alu_issue_stage_if.slave).
module alu_issue_stage (
   input logic             clk,
   input logic             reset,
   alu_issue_stage_if.slave bus
);
   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;
   localparam int unsigned CW = 3;

   localparam logic [CW-1:0] CTRL_ADD = 3'b000;
   localparam logic [CW-1:0] CTRL_SUB = 3'b001;
   localparam logic [CW-1:0] CTRL_XOR = 3'b010;
   localparam logic [CW-1:0] CTRL_BEQ = 3'b011;
   localparam logic [CW-1:0] CTRL_OR  = 3'b100;

   // instruction fields
   logic [5:0]    opcode;
   logic [RW-1:0] rs_idx, rt_idx, rd_idx;
   logic [5:0]    funct;
   logic [15:0]   imm;
   logic [4:0]    unused_shamt;

   assign opcode       = bus.instr[31:26];
   assign rs_idx       = bus.instr[25:21];
   assign rt_idx       = bus.instr[20:16];
   assign rd_idx       = bus.instr[15:11];
   assign unused_shamt = bus.instr[10:6];
   assign funct        = bus.instr[5:0];
   assign imm          = bus.instr[15:0];

   // ID/EX register
   logic [DW-1:0] alu_a_q, alu_a_d;
   logic [DW-1:0] alu_b_q, alu_b_d;
   logic [CW-1:0] alu_ctrl_q, alu_ctrl_d;
   logic          ex_valid_q, ex_valid_d;
   logic [RW-1:0] ex_rd_q, ex_rd_d;
   logic          ex_reg_wr_q, ex_reg_wr_d;
   logic          ex_mem_rd_q, ex_mem_rd_d;
   logic          ex_mem_wr_q, ex_mem_wr_d;
   logic [DW-1:0] ex_store_data_q, ex_store_data_d;
   logic [DW-1:0] ex_pc_q, ex_pc_d;
   logic          ex_illegal_q, ex_illegal_d;

   // Forwarding: EX/MEM beats MEM/WB beats regfile; r0 is hardwired to zero.
   function automatic logic [DW-1:0] fwd(input logic [RW-1:0] idx,
                                         input logic [DW-1:0] rf_val,
                                         input logic          exm_en,
                                         input logic [RW-1:0] exm_addr,
                                         input logic [DW-1:0] exm_data,
                                         input logic          mwb_en,
                                         input logic [RW-1:0] mwb_addr,
                                         input logic [DW-1:0] mwb_data);
      if (idx == RW'(0))                         return '0;
      else if (exm_en && (exm_addr == idx))      return exm_data;
      else if (mwb_en && (mwb_addr == idx))      return mwb_data;
      else                                       return rf_val;
   endfunction

   logic [DW-1:0] rs_fwd, rt_fwd;
   assign rs_fwd = fwd(rs_idx, bus.rs_data, bus.exm_wr_en, bus.exm_wr_addr, bus.exm_wr_data,
                       bus.mwb_wr_en, bus.mwb_wr_addr, bus.mwb_wr_data);
   assign rt_fwd = fwd(rt_idx, bus.rt_data, bus.exm_wr_en, bus.exm_wr_addr, bus.exm_wr_data,
                       bus.mwb_wr_en, bus.mwb_wr_addr, bus.mwb_wr_data);

   // Decode of the incoming instruction
   logic          dec_ok;
   logic [CW-1:0] dec_ctrl;
   logic [DW-1:0] dec_a, dec_b, dec_store;
   logic [RW-1:0] dec_rd;
   logic          dec_reg_wr, dec_mem_rd, dec_mem_wr;
   logic          uses_rt;

   always_comb begin
      dec_ok     = 1'b1;
      dec_ctrl   = CTRL_ADD;
      dec_a      = rs_fwd;
      dec_b      = rt_fwd;
      dec_store  = '0;
      dec_rd     = '0;
      dec_reg_wr = 1'b0;
      dec_mem_rd = 1'b0;
      dec_mem_wr = 1'b0;
      uses_rt    = 1'b0;
      case (opcode)
         6'h00: begin
            uses_rt    = 1'b1;
            dec_rd     = rd_idx;
            dec_reg_wr = 1'b1;
            case (funct)
               6'h20:   dec_ctrl = CTRL_ADD;
               6'h22:   dec_ctrl = CTRL_SUB;
               6'h26:   dec_ctrl = CTRL_XOR;
               6'h25:   dec_ctrl = CTRL_OR;
               default: dec_ok   = 1'b0;
            endcase
         end
         6'h08: begin
            dec_b      = {{16{imm[15]}}, imm};
            dec_rd     = rt_idx;
            dec_reg_wr = 1'b1;
         end
         6'h0D: begin
            dec_ctrl   = CTRL_OR;
            dec_b      = {16'h0000, imm};
            dec_rd     = rt_idx;
            dec_reg_wr = 1'b1;
         end
         6'h0E: begin
            dec_ctrl   = CTRL_XOR;
            dec_b      = {16'h0000, imm};
            dec_rd     = rt_idx;
            dec_reg_wr = 1'b1;
         end
         6'h23: begin
            dec_b      = {{16{imm[15]}}, imm};
            dec_rd     = rt_idx;
            dec_reg_wr = 1'b1;
            dec_mem_rd = 1'b1;
         end
         6'h2B: begin
            uses_rt    = 1'b1;
            dec_b      = {{16{imm[15]}}, imm};
            dec_mem_wr = 1'b1;
            dec_store  = rt_fwd;
         end
         6'h04: begin
            uses_rt  = 1'b1;
            dec_ctrl = CTRL_BEQ;
         end
         default: dec_ok = 1'b0;
      endcase
   end

   // Load in ID/EX whose destination is read by the incoming instruction
   logic hazard;
   assign hazard = ex_valid_q && ex_mem_rd_q && (ex_rd_q != RW'(0)) &&
                   ((ex_rd_q == rs_idx) || (uses_rt && (ex_rd_q == rt_idx)));

   assign bus.in_ready = !reset && (bus.flush || (!bus.ex_stall && !hazard));

   // Next ID/EX contents: bubble unless holding or loading
   always_comb begin
      alu_a_d         = '0;
      alu_b_d         = '0;
      alu_ctrl_d      = '0;
      ex_valid_d      = 1'b0;
      ex_rd_d         = '0;
      ex_reg_wr_d     = 1'b0;
      ex_mem_rd_d     = 1'b0;
      ex_mem_wr_d     = 1'b0;
      ex_store_data_d = '0;
      ex_pc_d         = '0;
      ex_illegal_d    = 1'b0;
      if (bus.flush) begin
         // bubble
      end else if (bus.ex_stall) begin
         alu_a_d         = alu_a_q;
         alu_b_d         = alu_b_q;
         alu_ctrl_d      = alu_ctrl_q;
         ex_valid_d      = ex_valid_q;
         ex_rd_d         = ex_rd_q;
         ex_reg_wr_d     = ex_reg_wr_q;
         ex_mem_rd_d     = ex_mem_rd_q;
         ex_mem_wr_d     = ex_mem_wr_q;
         ex_store_data_d = ex_store_data_q;
         ex_pc_d         = ex_pc_q;
         ex_illegal_d    = ex_illegal_q;
      end else if (hazard) begin
         // bubble
      end else if (bus.in_valid) begin
         if (dec_ok) begin
            alu_a_d         = dec_a;
            alu_b_d         = dec_b;
            alu_ctrl_d      = dec_ctrl;
            ex_valid_d      = 1'b1;
            ex_rd_d         = dec_rd;
            ex_reg_wr_d     = dec_reg_wr;
            ex_mem_rd_d     = dec_mem_rd;
            ex_mem_wr_d     = dec_mem_wr;
            ex_store_data_d = dec_store;
            ex_pc_d         = bus.pc;
         end else begin
            ex_illegal_d    = 1'b1;
         end
      end
   end

   // ID/EX register
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a_q         <= '0;
         alu_b_q         <= '0;
         alu_ctrl_q      <= '0;
         ex_valid_q      <= 1'b0;
         ex_rd_q         <= '0;
         ex_reg_wr_q     <= 1'b0;
         ex_mem_rd_q     <= 1'b0;
         ex_mem_wr_q     <= 1'b0;
         ex_store_data_q <= '0;
         ex_pc_q         <= '0;
         ex_illegal_q    <= 1'b0;
      end else begin
         alu_a_q         <= alu_a_d;
         alu_b_q         <= alu_b_d;
         alu_ctrl_q      <= alu_ctrl_d;
         ex_valid_q      <= ex_valid_d;
         ex_rd_q         <= ex_rd_d;
         ex_reg_wr_q     <= ex_reg_wr_d;
         ex_mem_rd_q     <= ex_mem_rd_d;
         ex_mem_wr_q     <= ex_mem_wr_d;
         ex_store_data_q <= ex_store_data_d;
         ex_pc_q         <= ex_pc_d;
         ex_illegal_q    <= ex_illegal_d;
      end
   end

   assign bus.alu_a         = alu_a_q;
   assign bus.alu_b         = alu_b_q;
   assign bus.alu_ctrl      = alu_ctrl_q;
   assign bus.ex_valid      = ex_valid_q;
   assign bus.ex_rd         = ex_rd_q;
   assign bus.ex_reg_wr     = ex_reg_wr_q;
   assign bus.ex_mem_rd     = ex_mem_rd_q;
   assign bus.ex_mem_wr     = ex_mem_wr_q;
   assign bus.ex_store_data = ex_store_data_q;
   assign bus.ex_pc         = ex_pc_q;
   assign bus.ex_illegal    = ex_illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, forwarding, load-use bubble,
// stall/flush, illegal opcode and reset. Inputs change on the falling edge;
// registered outputs are sampled on the following falling edge.
module tb_alu_issue_stage;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   alu_issue_stage_if bus ();

   alu_issue_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {6'h00, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".alu_a"},      bus.alu_a, 32'h0);
      chk({tag, ".alu_b"},      bus.alu_b, 32'h0);
      chk({tag, ".alu_ctrl"},   32'(bus.alu_ctrl), 32'h0);
      chk({tag, ".ex_valid"},   32'(bus.ex_valid), 32'h0);
      chk({tag, ".ex_rd"},      32'(bus.ex_rd), 32'h0);
      chk({tag, ".ex_reg_wr"},  32'(bus.ex_reg_wr), 32'h0);
      chk({tag, ".ex_mem_rd"},  32'(bus.ex_mem_rd), 32'h0);
      chk({tag, ".ex_mem_wr"},  32'(bus.ex_mem_wr), 32'h0);
      chk({tag, ".store_data"}, bus.ex_store_data, 32'h0);
      chk({tag, ".ex_pc"},      bus.ex_pc, 32'h0);
      chk({tag, ".ex_illegal"}, 32'(bus.ex_illegal), 32'h0);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] rsd, input logic [31:0] rtd);
      bus.in_valid = v;
      bus.instr    = ins;
      bus.pc       = p;
      bus.rs_data  = rsd;
      bus.rt_data  = rtd;
   endtask

   task automatic fwd_set(input logic xe, input logic [4:0] xa, input logic [31:0] xd,
                          input logic me, input logic [4:0] ma, input logic [31:0] md);
      bus.exm_wr_en   = xe;
      bus.exm_wr_addr = xa;
      bus.exm_wr_data = xd;
      bus.mwb_wr_en   = me;
      bus.mwb_wr_addr = ma;
      bus.mwb_wr_data = md;
   endtask

   initial begin
      reset        = 1'b1;
      bus.ex_stall = 1'b0;
      bus.flush    = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst.in_ready", 32'(bus.in_ready), 32'h0);
      chk_all_zero("rst");
      reset = 1'b0;

      // ADD r3 = r1 + r2
      drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h100, 32'd5, 32'd7);
      #1 chk("add.in_ready", 32'(bus.in_ready), 32'h1);
      @(negedge clk);
      chk("add.ctrl",   32'(bus.alu_ctrl), 32'h0);
      chk("add.a",      bus.alu_a, 32'd5);
      chk("add.b",      bus.alu_b, 32'd7);
      chk("add.rd",     32'(bus.ex_rd), 32'd3);
      chk("add.reg_wr", 32'(bus.ex_reg_wr), 32'h1);
      chk("add.valid",  32'(bus.ex_valid), 32'h1);
      chk("add.pc",     bus.ex_pc, 32'h100);

      // ADDI r4 = r1 + sext(0xFFFF)
      drive(1'b1, itype(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'h104, 32'd1, 32'd0);
      @(negedge clk);
      chk("addi.b",    bus.alu_b, 32'hFFFF_FFFF);
      chk("addi.a",    bus.alu_a, 32'd1);
      chk("addi.rd",   32'(bus.ex_rd), 32'd4);
      chk("addi.ctrl", 32'(bus.alu_ctrl), 32'h0);

      // ORI r5 = r1 | zext(0xFFFF)
      drive(1'b1, itype(6'h0D, 5'd1, 5'd5, 16'hFFFF), 32'h108, 32'd1, 32'd0);
      @(negedge clk);
      chk("ori.b",    bus.alu_b, 32'h0000_FFFF);
      chk("ori.ctrl", 32'(bus.alu_ctrl), 32'h4);
      chk("ori.rd",   32'(bus.ex_rd), 32'd5);

      // XORI zero-extends too
      drive(1'b1, itype(6'h0E, 5'd1, 5'd6, 16'h8001), 32'h10C, 32'd1, 32'd0);
      @(negedge clk);
      chk("xori.b",    bus.alu_b, 32'h0000_8001);
      chk("xori.ctrl", 32'(bus.alu_ctrl), 32'h2);

      // forwarding: EX/MEM beats MEM/WB
      fwd_set(1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
      drive(1'b1, rtype(5'd4, 5'd2, 5'd7, 6'h20), 32'h110, 32'h11, 32'h22);
      @(negedge clk);
      chk("fwd_exm.a", bus.alu_a, 32'hAA);
      chk("fwd_exm.b", bus.alu_b, 32'h22);

      // MEM/WB used when EX/MEM not writing
      fwd_set(1'b0, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
      @(negedge clk);
      chk("fwd_mwb.a", bus.alu_a, 32'hBB);

      // r0 reads zero despite matching writers
      fwd_set(1'b1, 5'd0, 32'hCC, 1'b1, 5'd0, 32'hDD);
      drive(1'b1, rtype(5'd0, 5'd0, 5'd7, 6'h20), 32'h114, 32'h55, 32'h66);
      @(negedge clk);
      chk("fwd_r0.a", bus.alu_a, 32'h0);
      chk("fwd_r0.b", bus.alu_b, 32'h0);
      fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // SUB, OR funct codes
      drive(1'b1, rtype(5'd1, 5'd2, 5'd9, 6'h22), 32'h118, 32'd9, 32'd4);
      @(negedge clk);
      chk("sub.ctrl", 32'(bus.alu_ctrl), 32'h1);
      drive(1'b1, rtype(5'd1, 5'd2, 5'd9, 6'h25), 32'h11C, 32'd9, 32'd4);
      @(negedge clk);
      chk("or.ctrl", 32'(bus.alu_ctrl), 32'h4);

      // LW r8, 4(r1) then ADD r10 = r8 + r2 -> one bubble
      drive(1'b1, itype(6'h23, 5'd1, 5'd8, 16'h0004), 32'h120, 32'h1000, 32'h0);
      @(negedge clk);
      chk("lw.a",      bus.alu_a, 32'h1000);
      chk("lw.b",      bus.alu_b, 32'h4);
      chk("lw.mem_rd", 32'(bus.ex_mem_rd), 32'h1);
      chk("lw.rd",     32'(bus.ex_rd), 32'd8);
      chk("lw.reg_wr", 32'(bus.ex_reg_wr), 32'h1);
      drive(1'b1, rtype(5'd8, 5'd2, 5'd10, 6'h20), 32'h124, 32'h0, 32'h3);
      #1 chk("luse.in_ready", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
      chk("luse.bubble",    32'(bus.ex_valid), 32'h0);
      chk("luse.in_ready2", 32'(bus.in_ready), 32'h1);
      fwd_set(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h77);
      @(negedge clk);
      chk("luse.add_valid", 32'(bus.ex_valid), 32'h1);
      chk("luse.add_a",     bus.alu_a, 32'h77);
      chk("luse.add_rd",    32'(bus.ex_rd), 32'd10);
      fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // SW r6, -8(r1)
      drive(1'b1, itype(6'h2B, 5'd1, 5'd6, 16'hFFF8), 32'h128, 32'h200, 32'hDEAD);
      @(negedge clk);
      chk("sw.a",      bus.alu_a, 32'h200);
      chk("sw.b",      bus.alu_b, 32'hFFFF_FFF8);
      chk("sw.mem_wr", 32'(bus.ex_mem_wr), 32'h1);
      chk("sw.store",  bus.ex_store_data, 32'hDEAD);
      chk("sw.rd",     32'(bus.ex_rd), 32'd0);
      chk("sw.reg_wr", 32'(bus.ex_reg_wr), 32'h0);

      // stall 3 cycles with BEQ waiting: SW held, input refused
      drive(1'b1, itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'h12C, 32'd3, 32'd3);
      bus.ex_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall.in_ready", 32'(bus.in_ready), 32'h0);
         @(negedge clk);
         chk("stall.a",     bus.alu_a, 32'h200);
         chk("stall.store", bus.ex_store_data, 32'hDEAD);
         chk("stall.valid", 32'(bus.ex_valid), 32'h1);
      end

      // flush with stall: flush wins
      bus.flush = 1'b1;
      #1 chk("flush.in_ready", 32'(bus.in_ready), 32'h1);
      @(negedge clk);
      chk("flush.valid", 32'(bus.ex_valid), 32'h0);
      chk("flush.a",     bus.alu_a, 32'h0);
      bus.flush    = 1'b0;
      bus.ex_stall = 1'b0;

      // BEQ accepted afterwards
      @(negedge clk);
      chk("beq.ctrl",   32'(bus.alu_ctrl), 32'h3);
      chk("beq.a",      bus.alu_a, 32'd3);
      chk("beq.b",      bus.alu_b, 32'd3);
      chk("beq.rd",     32'(bus.ex_rd), 32'd0);
      chk("beq.reg_wr", 32'(bus.ex_reg_wr), 32'h0);

      // illegal opcode 0x3F: one-cycle ex_illegal
      drive(1'b1, itype(6'h3F, 5'd1, 5'd2, 16'h0), 32'h130, 32'd1, 32'd2);
      @(negedge clk);
      chk("ill.illegal", 32'(bus.ex_illegal), 32'h1);
      chk("ill.valid",   32'(bus.ex_valid), 32'h0);
      chk("ill.reg_wr",  32'(bus.ex_reg_wr), 32'h0);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("ill.cleared", 32'(bus.ex_illegal), 32'h0);

      // unknown R-type funct is illegal as well
      drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h3F), 32'h134, 32'd1, 32'd2);
      @(negedge clk);
      chk("illf.illegal", 32'(bus.ex_illegal), 32'h1);
      chk("illf.valid",   32'(bus.ex_valid), 32'h0);

      // mid-sequence reset
      drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h138, 32'd5, 32'd7);
      @(negedge clk);
      chk("pre_rst.valid", 32'(bus.ex_valid), 32'h1);
      reset = 1'b1;
      #1 chk("mid_rst.in_ready", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
      chk_all_zero("mid_rst");
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
